// File: rtl/pool_relu_stream.sv
// Streaming multi-lane window pooling (MAX/MIN/AVG) with optional bias, ReLU and saturation.
// One accumulator lane per channel; a small FSM frames windows and sequences the two-stage result pipeline.

module pool_relu_lane #(
  parameter int DATA_WID  = 16,
  parameter int MAX_WIN   = 16,
  parameter int RECIP_WID = 16
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic                 beat_i,
  input  logic                 first_i,
  input  logic                 mask_i,
  input  logic [DATA_WID-1:0]  data_i,
  input  logic                 is_avg_i,
  input  logic                 is_min_i,
  input  logic                 bias_en_i,
  input  logic                 relu_en_i,
  input  logic [DATA_WID-1:0]  bias_i,
  input  logic [RECIP_WID-1:0] recip_i,
  input  logic                 fin_i,
  input  logic                 st2_i,
  output logic [DATA_WID-1:0]  res_o,
  output logic                 seen_o
);
  localparam int AW = DATA_WID + $clog2(MAX_WIN + 1);
  localparam int PW = AW + RECIP_WID + 1;
  localparam int EW = PW + 1;
  localparam logic signed [PW-1:0] HALF = {{(PW-RECIP_WID){1'b0}}, 1'b1, {(RECIP_WID-1){1'b0}}};
  localparam logic signed [EW-1:0] SMAX = {{(EW-DATA_WID+1){1'b0}}, {(DATA_WID-1){1'b1}}};
  localparam logic signed [EW-1:0] SMIN = {{(EW-DATA_WID+1){1'b1}}, {(DATA_WID-1){1'b0}}};

  logic signed [AW-1:0] acc_q, acc_d, dext;
  logic                 seen_q, seen_d;
  logic signed [PW-1:0] acc_x, rcp_x, prod_w, avg_w;
  logic signed [EW-1:0] pool_w, bext, p1_q, p1_d, p2_w;
  logic [DATA_WID-1:0]  res_q, res_d;
  logic                 msk_q;

  assign dext = {{(AW-DATA_WID){data_i[DATA_WID-1]}}, data_i};

  always_comb begin
    acc_d  = acc_q;
    seen_d = seen_q;
    if (beat_i) begin
      if (first_i) begin
        seen_d = mask_i;
        acc_d  = mask_i ? dext : '0;
      end else if (mask_i) begin
        seen_d = 1'b1;
        if (!seen_q)       acc_d = dext;
        else if (is_avg_i) acc_d = acc_q + dext;
        else if (is_min_i) acc_d = (dext < acc_q) ? dext : acc_q;
        else               acc_d = (dext > acc_q) ? dext : acc_q;
      end
    end
  end

  // Stage 1 (FIN): reciprocal-multiply average with round half up, then bias at full precision.
  assign acc_x  = {{(PW-AW){acc_q[AW-1]}}, acc_q};
  assign rcp_x  = {{(PW-RECIP_WID){1'b0}}, recip_i};
  assign prod_w = acc_x * rcp_x;
  assign avg_w  = (prod_w + HALF) >>> RECIP_WID;
  assign pool_w = is_avg_i ? {avg_w[PW-1], avg_w} : {{(EW-AW){acc_q[AW-1]}}, acc_q};
  assign bext   = bias_en_i ? {{(EW-DATA_WID){bias_i[DATA_WID-1]}}, bias_i} : '0;
  assign p1_d   = seen_q ? (pool_w + bext) : '0;

  // Stage 2: ReLU then saturate to the data width.
  assign p2_w = (relu_en_i && p1_q[EW-1]) ? '0 : p1_q;
  always_comb begin
    res_d = p2_w[DATA_WID-1:0];
    if (p2_w > SMAX)      res_d = SMAX[DATA_WID-1:0];
    else if (p2_w < SMIN) res_d = SMIN[DATA_WID-1:0];
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      acc_q  <= '0;
      seen_q <= 1'b0;
      p1_q   <= '0;
      res_q  <= '0;
      msk_q  <= 1'b0;
    end else begin
      acc_q  <= acc_d;
      seen_q <= seen_d;
      if (fin_i) p1_q <= p1_d;
      if (st2_i) begin
        res_q <= res_d;
        msk_q <= seen_q;
      end
    end
  end

  assign res_o  = res_q;
  assign seen_o = msk_q;
endmodule

module pool_relu_stream #(
  parameter int DATA_WID  = 16,
  parameter int NCH       = 4,
  parameter int MAX_WIN   = 16,
  parameter int RECIP_WID = 16
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    in_valid,
  output logic                    in_ready,
  input  logic                    in_last,
  input  logic [NCH-1:0]          in_mask,
  input  logic [NCH*DATA_WID-1:0] in_data,
  input  logic [1:0]              in_mode,
  input  logic                    in_bias_en,
  input  logic                    in_relu_en,
  input  logic [NCH*DATA_WID-1:0] in_bias,
  input  logic [RECIP_WID-1:0]    in_avg_recip,
  output logic                    out_valid,
  input  logic                    out_ready,
  output logic [NCH*DATA_WID-1:0] out_data,
  output logic [NCH-1:0]          out_mask
);
  localparam int CW = $clog2(MAX_WIN + 1);

  typedef enum logic [1:0] {S_IDLE, S_ACC, S_FIN, S_HOLD} state_t;
  state_t st_q, st_d;

  logic [CW-1:0]           cnt_q, cnt_nxt;
  logic [1:0]              mode_q;
  logic                    bias_en_q, relu_en_q, fin_q, out_valid_q;
  logic [NCH*DATA_WID-1:0] bias_q;
  logic [RECIP_WID-1:0]    recip_q;
  logic                    beat, first, last_eff;
  logic [NCH-1:0][DATA_WID-1:0] lane_res;
  logic [NCH-1:0]          lane_msk;

  assign in_ready = reset && (st_q == S_IDLE || st_q == S_ACC);
  assign beat     = in_valid && in_ready;
  assign first    = beat && (st_q == S_IDLE);
  assign cnt_nxt  = first ? CW'(1) : cnt_q + CW'(1);
  assign last_eff = in_last || (cnt_nxt == CW'(MAX_WIN));

  always_comb begin
    st_d = st_q;
    case (st_q)
      S_IDLE: if (beat) st_d = last_eff ? S_FIN : S_ACC;
      S_ACC:  if (beat && last_eff) st_d = S_FIN;
      S_FIN:  st_d = S_HOLD;
      S_HOLD: if (out_valid_q && out_ready) st_d = S_IDLE;
      default: st_d = S_IDLE;
    endcase
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      st_q        <= S_IDLE;
      cnt_q       <= '0;
      mode_q      <= '0;
      bias_en_q   <= 1'b0;
      relu_en_q   <= 1'b0;
      bias_q      <= '0;
      recip_q     <= '0;
      fin_q       <= 1'b0;
      out_valid_q <= 1'b0;
    end else begin
      st_q  <= st_d;
      fin_q <= (st_q == S_FIN);
      if (beat) cnt_q <= cnt_nxt;
      // Window configuration is frozen by its first beat.
      if (first) begin
        mode_q    <= in_mode;
        bias_en_q <= in_bias_en;
        relu_en_q <= in_relu_en;
        bias_q    <= in_bias;
        recip_q   <= in_avg_recip;
      end
      if (fin_q)                          out_valid_q <= 1'b1;
      else if (out_valid_q && out_ready) out_valid_q <= 1'b0;
    end
  end

  for (genvar g = 0; g < NCH; g++) begin : g_lane
    pool_relu_lane #(
      .DATA_WID(DATA_WID), .MAX_WIN(MAX_WIN), .RECIP_WID(RECIP_WID)
    ) u_lane (
      .clk       (clk),
      .reset     (reset),
      .beat_i    (beat),
      .first_i   (first),
      .mask_i    (in_mask[g]),
      .data_i    (in_data[g*DATA_WID +: DATA_WID]),
      .is_avg_i  (mode_q == 2'b01),
      .is_min_i  (mode_q == 2'b10),
      .bias_en_i (bias_en_q),
      .relu_en_i (relu_en_q),
      .bias_i    (bias_q[g*DATA_WID +: DATA_WID]),
      .recip_i   (recip_q),
      .fin_i     (st_q == S_FIN),
      .st2_i     (fin_q),
      .res_o     (lane_res[g]),
      .seen_o    (lane_msk[g])
    );
  end

  assign out_valid = out_valid_q;
  assign out_data  = lane_res;
  assign out_mask  = lane_msk;
endmodule

// File: tb/tb_pool_relu_stream.sv
// Directed bench for pool_relu_stream: window-level reference model plus literal expectations.

module tb_pool_relu_stream;
  localparam int DW = 16, NCH = 4, MW = 16, RW = 16;

  logic              clk = 1'b0, reset;
  logic              in_valid, in_ready, in_last, in_bias_en, in_relu_en, out_valid, out_ready;
  logic [NCH-1:0]    in_mask, out_mask;
  logic [NCH*DW-1:0] in_data, in_bias, out_data;
  logic [1:0]        in_mode;
  logic [RW-1:0]     in_avg_recip;

  int checks = 0, errors = 0;

  typedef struct packed { logic [NCH*DW-1:0] d; logic [NCH-1:0] m; } res_t;
  res_t exp_q[$];
  res_t mon_e;
  logic [NCH*DW-1:0] w_d[$];
  logic [NCH-1:0]    w_m[$];
  logic [1:0]        c_mode;
  logic              c_ben, c_ren;
  logic [NCH*DW-1:0] c_bias;
  logic [RW-1:0]     c_rcp;
  logic              hold_q;
  logic [NCH*DW-1:0] hold_d;
  logic [NCH-1:0]    hold_m;

  pool_relu_stream #(.DATA_WID(DW), .NCH(NCH), .MAX_WIN(MW), .RECIP_WID(RW)) dut (
    .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready), .in_last(in_last),
    .in_mask(in_mask), .in_data(in_data), .in_mode(in_mode), .in_bias_en(in_bias_en),
    .in_relu_en(in_relu_en), .in_bias(in_bias), .in_avg_recip(in_avg_recip),
    .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data), .out_mask(out_mask)
  );

  always #5 clk = ~clk;

  function automatic logic [NCH*DW-1:0] p(int a, int b, int c, int d);
    int v[4];
    logic [NCH*DW-1:0] r;
    v = '{a, b, c, d};
    for (int i = 0; i < NCH; i++) r[i*DW +: DW] = v[i][DW-1:0];
    return r;
  endfunction

  // Reference: fold the whole window per lane with plain integer arithmetic.
  function automatic res_t model_close();
    res_t   r;
    longint hi, lo;
    hi = (longint'(1) <<< (DW-1)) - 1;
    lo = -hi - 1;
    r = '0;
    for (int i = 0; i < NCH; i++) begin
      longint v, x;
      bit seen;
      logic signed [DW-1:0] s, bs;
      v = 0; seen = 0;
      for (int b = 0; b < w_d.size(); b++) begin
        if (w_m[b][i]) begin
          s = w_d[b][i*DW +: DW];
          x = longint'(s);
          if (!seen)                v = x;
          else if (c_mode == 2'b01) v = v + x;
          else if (c_mode == 2'b10) v = (x < v) ? x : v;
          else                      v = (x > v) ? x : v;
          seen = 1;
        end
      end
      if (seen) begin
        if (c_mode == 2'b01) v = (v * longint'(c_rcp) + (longint'(1) <<< (RW-1))) >>> RW;
        bs = c_bias[i*DW +: DW];
        if (c_ben) v = v + longint'(bs);
        if (c_ren && v < 0) v = 0;
        if (v > hi) v = hi;
        if (v < lo) v = lo;
        r.d[i*DW +: DW] = v[DW-1:0];
        r.m[i] = 1'b1;
      end
    end
    return r;
  endfunction

  function automatic void model_accept();
    if (w_d.size() == 0) begin
      c_mode = in_mode; c_ben = in_bias_en; c_ren = in_relu_en; c_bias = in_bias; c_rcp = in_avg_recip;
    end
    w_d.push_back(in_data);
    w_m.push_back(in_mask);
    if (in_last || w_d.size() == MW) begin
      exp_q.push_back(model_close());
      w_d.delete();
      w_m.delete();
    end
  endfunction

  task automatic chk(input string name, input logic [127:0] act, input logic [127:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Called at posedge+1; returns at posedge+1 after the beat is taken.
  task automatic beat(input logic [NCH*DW-1:0] d, input logic [NCH-1:0] m, input logic l);
    int n;
    in_valid = 1'b1; in_data = d; in_mask = m; in_last = l;
    n = 0;
    while (!in_ready && n < 200) begin
      @(posedge clk); #1; n++;
    end
    if (!in_ready) chk("beat_accept_timeout", 0, 1);
    else begin
      model_accept();
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0;
  endtask

  task automatic expect_lit(input string name, input logic [NCH*DW-1:0] d, input logic [NCH-1:0] m, input int lat);
    int n;
    n = 0;
    do begin
      @(negedge clk); n++;
    end while (!out_valid && n < 50);
    chk({name, "_valid"}, out_valid, 1);
    chk({name, "_data"}, out_data, d);
    chk({name, "_mask"}, out_mask, m);
    if (lat != 0) chk({name, "_latency"}, n, lat);
    @(posedge clk); #1;
  endtask

  // Monitor: every handshake against the model; output held while stalled.
  initial begin
    hold_q = 1'b0;
    forever begin
      @(negedge clk);
      if (!reset) hold_q = 1'b0;
      else begin
        if (hold_q) chk("hold_stable", {out_valid, out_mask, out_data}, {1'b1, hold_m, hold_d});
        if (out_valid && out_ready) begin
          if (exp_q.size() == 0) chk("unexpected_output", 1, 0);
          else begin
            mon_e = exp_q.pop_front();
            chk("model_result", {out_mask, out_data}, {mon_e.m, mon_e.d});
          end
        end
        hold_q = out_valid && !out_ready;
        hold_d = out_data;
        hold_m = out_mask;
      end
    end
  end

  initial begin
    #300000;
    $display("FAIL watchdog: simulation did not finish");
    $fatal(1, "watchdog");
  end

  initial begin
    reset = 1'b0; in_valid = 0; in_last = 0; in_mask = '0; in_data = '0; in_mode = 2'b00;
    in_bias_en = 0; in_relu_en = 0; in_bias = '0; in_avg_recip = '0; out_ready = 1'b1;
    repeat (2) @(posedge clk); #1;
    chk("reset_outputs", {in_ready, out_valid, out_mask, out_data}, '0);
    reset = 1'b1; #1;
    chk("idle_ready", in_ready, 1);
    @(posedge clk); #1;

    // MAX, full mask, latency 2 edges after last
    beat(p(11, 12, 13, 14), 4'hf, 0);
    beat(p(18, 15, 16, 17), 4'hf, 0);
    beat(p(19, 22, 20, 21), 4'hf, 1);
    expect_lit("max", p(19, 22, 20, 21), 4'hf, 3);

    // AVG with bias; config changes after the first beat are ignored
    in_mode = 2'b01; in_bias_en = 1; in_bias = p(1, 2, 3, 4); in_avg_recip = 16'd16384;
    beat(p(2, 3, 3, 2), 4'hf, 0);
    in_bias = p(100, 100, 100, 100); in_mode = 2'b00; in_avg_recip = 16'd1;
    beat(p(2, 3, 3, 2), 4'hf, 0);
    beat(p(2, 3, 3, 2), 4'hf, 0);
    beat(p(2, 3, 3, 2), 4'hf, 1);
    expect_lit("avg_bias", p(3, 5, 6, 6), 4'hf, 0);
    in_mode = 2'b01; in_bias_en = 0; in_avg_recip = 16'd21845;
    beat(p(5, 5, 5, -5), 4'hf, 0);
    beat(p(5, 5, 5, -5), 4'hf, 1);
    expect_lit("avg_round", p(3, 3, 3, -3), 4'hf, 0);

    // MIN + ReLU, then saturation both ways
    in_mode = 2'b10; in_relu_en = 1;
    beat(p(-2, -3, 5, 0), 4'hf, 0);
    beat(p(-1, 4, 6, -7), 4'hf, 1);
    expect_lit("min_relu", p(0, 0, 5, 0), 4'hf, 0);
    in_mode = 2'b00; in_relu_en = 0; in_bias_en = 1; in_bias = p(1, -1, 0, 0);
    beat(p(32767, -32768, 0, 0), 4'hf, 1);
    expect_lit("saturate", p(32767, -32768, 0, 0), 4'hf, 0);

    // Per-lane masks; unmasked lanes give 0 and skip bias
    in_bias_en = 0;
    beat(p(10, 99, 99, 99), 4'b0001, 0);
    beat(p(99, -20, 99, 99), 4'b0010, 0);
    beat(p(99, 99, 30, 99), 4'b0100, 0);
    beat(p(99, 99, 99, -40), 4'b1000, 1);
    expect_lit("masks", p(10, -20, 30, -40), 4'hf, 0);
    in_bias_en = 1; in_bias = p(5, 5, 5, 5);
    beat(p(1, 2, 99, 99), 4'b0011, 0);
    beat(p(3, 1, 99, 99), 4'b0011, 1);
    expect_lit("empty_lane", p(8, 7, 0, 0), 4'b0011, 0);

    // Backpressure: output held, input blocked, stray beats ignored
    in_bias_en = 0; out_ready = 1'b0;
    beat(p(-1, -2, -3, -4), 4'hf, 1);
    expect_lit("bp_first", p(-1, -2, -3, -4), 4'hf, 0);
    for (int k = 0; k < 5; k++) begin
      in_valid = k[0]; in_last = 1'b1; in_data = p(50, 50, 50, 50); in_mask = 4'hf;
      @(negedge clk);
      chk("bp_in_ready", in_ready, 0);
      @(posedge clk); #1;
    end
    in_valid = 1'b0; in_last = 1'b0; out_ready = 1'b1;
    @(posedge clk); #1;
    chk("bp_release", {out_valid, in_ready}, 2'b01);

    // Reset mid-window discards partial state
    beat(p(100, 100, 100, 100), 4'hf, 0);
    beat(p(100, 100, 100, 100), 4'hf, 0);
    reset = 1'b0; #1;
    chk("midreset_outputs", {in_ready, out_valid, out_mask, out_data}, '0);
    w_d.delete(); w_m.delete();
    @(posedge clk); #1;
    reset = 1'b1;
    @(posedge clk); #1;
    beat(p(7, 7, 7, 7), 4'hf, 1);
    expect_lit("after_reset", p(7, 7, 7, 7), 4'hf, 0);

    // MAX_WIN+1 beats without in_last: forced close at beat MAX_WIN
    for (int k = 1; k <= MW; k++) beat(p(k, -k, k, 0), 4'hf, 0);
    chk("forced_fin_ready", in_ready, 0);
    expect_lit("forced_last", p(16, -1, 16, 0), 4'hf, 3);
    beat(p(17, -17, 17, 0), 4'hf, 1);
    expect_lit("after_forced", p(17, -17, 17, 0), 4'hf, 0);

    repeat (3) @(posedge clk); #1;
    chk("model_drained", exp_q.size(), 0);
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end
endmodule
